// File: rtl/hazard_sched_if.sv
// Hazard sequencer bundle.
//   Hazard inputs (rs/rd fields, memread, redirect, dmem handshake, halt/resume)
//   are driven by the master side. Pipeline controls, status and performance
//   counters are driven by the slave side (hazard_sched).
interface hazard_sched_if #(parameter int CNT_W = 32);
  logic [4:0]       if_id_rs1, if_id_rs2, id_ex_rd;
  logic             id_ex_memread, ex_redirect, dmem_req, dmem_ack, halt_req, resume;
  logic             pc_en, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output if_id_rs1, if_id_rs2, id_ex_rd, id_ex_memread, ex_redirect,
           dmem_req, dmem_ack, halt_req, resume,
    input  pc_en, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_err,
           stall_cnt, flush_cnt
  );
  modport slave (
    input  if_id_rs1, if_id_rs2, id_ex_rd, id_ex_memread, ex_redirect,
           dmem_req, dmem_ack, halt_req, resume,
    output pc_en, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_err,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sched.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : hazard inputs in; PC / pipeline-register enables and
//                  flushes, halted, sticky mem_err and saturating
//                  stall/flush counters out.
// Control outputs are combinational from state and inputs; FSM, wait/LU
// counters, mem_err and perf counters are registered.
module hazard_sched #(
  parameter int LU_STALL    = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  hazard_sched_if.slave   bus
);
  typedef enum logic [1:0] {RUN, LU_WAIT, MEM_WAIT, HALT} state_t;
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]       lu_cnt_q, lu_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic lu_hit, freeze, rdr_taken;
  logic pc_en, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush, halted;

  assign lu_hit = bus.id_ex_memread && (bus.id_ex_rd != 5'd0) &&
                  ((bus.id_ex_rd == bus.if_id_rs1) || (bus.id_ex_rd == bus.if_id_rs2));
  // Outstanding data access without completion freezes everything up to EX/MEM.
  assign freeze = bus.dmem_req && !bus.dmem_ack && (state_q != HALT);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    lu_cnt_d     = lu_cnt_q;
    mem_err_d    = mem_err_q;
    rdr_taken    = 1'b0;
    pc_en        = 1'b1;
    pc_sel       = 1'b0;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    halted       = 1'b0;

    if (state_q == HALT) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
      halted     = 1'b1;
      wait_cnt_d = '0;
      if (bus.resume) state_d = RUN;
    end else if (freeze) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0;
      mem_wb_flush = 1'b1;
      wait_cnt_d   = wait_cnt_q + 1'b1;
      // LU_WAIT keeps its state so the remaining bubble count survives the freeze.
      if (state_q != LU_WAIT) state_d = MEM_WAIT;
      if (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) begin
        state_d   = HALT;
        mem_err_d = 1'b1;
      end
    end else if (state_q == LU_WAIT) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      wait_cnt_d  = '0;
      lu_cnt_d    = lu_cnt_q - 2'd1;
      if (lu_cnt_q == 2'd1) state_d = RUN;
    end else begin
      // RUN, or MEM_WAIT on its ack cycle: behaves as RUN.
      state_d    = RUN;
      wait_cnt_d = '0;
      if (bus.halt_req) begin
        state_d = HALT;
      end else if (bus.ex_redirect) begin
        pc_sel      = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        rdr_taken   = 1'b1;
      end else if (lu_hit) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        if (LU_STALL > 1) begin
          state_d  = LU_WAIT;
          lu_cnt_d = 2'(LU_STALL - 1);
        end
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (state_q != HALT) && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (rdr_taken && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      lu_cnt_q    <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Reset forces every control low regardless of state/inputs.
  assign bus.pc_en        = reset_n & pc_en;
  assign bus.pc_sel       = reset_n & pc_sel;
  assign bus.if_id_en     = reset_n & if_id_en;
  assign bus.id_ex_en     = reset_n & id_ex_en;
  assign bus.ex_mem_en    = reset_n & ex_mem_en;
  assign bus.mem_wb_en    = reset_n & mem_wb_en;
  assign bus.if_id_flush  = reset_n & if_id_flush;
  assign bus.id_ex_flush  = reset_n & id_ex_flush;
  assign bus.mem_wb_flush = reset_n & mem_wb_flush;
  assign bus.halted       = reset_n & halted;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: two instances (LU_STALL=1 and 2).
// Stimulus pushes per-cycle expected controls/counters; a negedge monitor
// pops and compares against the selected instance.
module tb_hazard_sched;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hazard_sched_if #(.CNT_W(32)) ifa ();
  hazard_sched_if #(.CNT_W(32)) ifb ();

  hazard_sched #(.LU_STALL(1), .MEM_TIMEOUT(15), .CNT_W(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(ifa));
  hazard_sched #(.LU_STALL(2), .MEM_TIMEOUT(15), .CNT_W(32)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .bus(ifb));

  // ctrl order: pc_en pc_sel if_id_en id_ex_en ex_mem_en mem_wb_en
  //             if_id_flush id_ex_flush mem_wb_flush halted mem_err
  localparam logic [10:0] ZERO = 11'b00000000000;
  localparam logic [10:0] RUNV = 11'b10111100000;
  localparam logic [10:0] LUV  = 11'b00011101000;
  localparam logic [10:0] FRZ  = 11'b00000100100;
  localparam logic [10:0] RDR  = 11'b11111111000;
  localparam logic [10:0] HLT  = 11'b00000000010;
  localparam logic [10:0] ERR  = 11'b00000000001;

  typedef struct {
    bit          sel;
    logic [10:0] ctrl;
    int unsigned stall;
    int unsigned flush;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_err = 0;

  exp_t        e;
  logic [10:0] act;
  logic [31:0] act_st, act_fl;

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.sel) begin
        act    = {ifb.pc_en, ifb.pc_sel, ifb.if_id_en, ifb.id_ex_en, ifb.ex_mem_en, ifb.mem_wb_en,
                  ifb.if_id_flush, ifb.id_ex_flush, ifb.mem_wb_flush, ifb.halted, ifb.mem_err};
        act_st = ifb.stall_cnt;
        act_fl = ifb.flush_cnt;
      end else begin
        act    = {ifa.pc_en, ifa.pc_sel, ifa.if_id_en, ifa.id_ex_en, ifa.ex_mem_en, ifa.mem_wb_en,
                  ifa.if_id_flush, ifa.id_ex_flush, ifa.mem_wb_flush, ifa.halted, ifa.mem_err};
        act_st = ifa.stall_cnt;
        act_fl = ifa.flush_cnt;
      end
      n_cmp++;
      if (act !== e.ctrl) begin
        n_err++;
        $display("FAIL %s ctrl: got %b want %b", e.name, act, e.ctrl);
      end
      n_cmp++;
      if (act_st !== e.stall || act_fl !== e.flush) begin
        n_err++;
        $display("FAIL %s cnt: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 e.name, act_st, act_fl, e.stall, e.flush);
      end
    end
  end

  task automatic set_a(bit mr, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                       bit rdr, bit req, bit ack, bit hr, bit rsm);
    ifa.id_ex_memread = mr;  ifa.id_ex_rd  = rd;  ifa.if_id_rs1 = rs1; ifa.if_id_rs2 = rs2;
    ifa.ex_redirect   = rdr; ifa.dmem_req  = req; ifa.dmem_ack  = ack;
    ifa.halt_req      = hr;  ifa.resume    = rsm;
  endtask

  task automatic set_b(bit mr, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    ifb.id_ex_memread = mr;   ifb.id_ex_rd  = rd;   ifb.if_id_rs1 = rs1; ifb.if_id_rs2 = rs2;
    ifb.ex_redirect   = 1'b0; ifb.dmem_req  = 1'b0; ifb.dmem_ack  = 1'b0;
    ifb.halt_req      = 1'b0; ifb.resume    = 1'b0;
  endtask

  // Called at posedge+1 with inputs already applied; checked at the next negedge.
  task automatic step(bit sel, logic [10:0] ctrl, int unsigned st, int unsigned fl, string nm);
    exp_t x;
    x.sel = sel; x.ctrl = ctrl; x.stall = st; x.flush = fl; x.name = nm;
    sbq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout want finish");
    summary();
    $finish;
  end

  initial begin
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    @(posedge clk);
    #1;
    step(0, ZERO, 0, 0, "reset_a");
    step(1, ZERO, 0, 0, "reset_b");
    reset_n = 1'b1;
    step(0, RUNV, 0, 0, "idle");
    // load-use, LU_STALL=1
    set_a(1, 5, 5, 0, 0, 0, 0, 0, 0); step(0, LUV,  0, 0, "lu_rs1");
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, RUNV, 1, 0, "lu_done");
    set_a(1, 0, 0, 0, 0, 0, 0, 0, 0); step(0, RUNV, 1, 0, "lu_rd0");
    set_a(1, 5, 6, 4, 0, 0, 0, 0, 0); step(0, RUNV, 1, 0, "lu_nomatch");
    // redirect beats load-use
    set_a(1, 5, 5, 0, 1, 0, 0, 0, 0); step(0, RDR,  1, 0, "redirect_lu");
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, RUNV, 1, 1, "redirect_done");
    // memory wait: 3 frozen cycles then ack
    set_a(0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, FRZ, 1 + i, 1, "mem_wait");
    set_a(0, 0, 0, 0, 0, 1, 1, 0, 0); step(0, RUNV, 4, 1, "mem_ack");
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, RUNV, 4, 1, "mem_idle");
    // timeout: 15 frozen cycles, then HALT with mem_err
    set_a(0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(0, FRZ, 4 + i, 1, "timeout_frz");
    step(0, HLT | ERR, 19, 1, "timeout_halt");
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, HLT | ERR, 19, 1, "halt_hold");
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 1); step(0, HLT | ERR, 19, 1, "resume_cyc");
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, RUNV | ERR, 19, 1, "resumed");
    // halt_req beats redirect and load-use
    set_a(1, 5, 5, 0, 1, 0, 0, 1, 0); step(0, RUNV | ERR, 19, 1, "halt_req");
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, HLT | ERR, 19, 1, "halted");
    step(0, HLT | ERR, 19, 1, "halted2");
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 1); step(0, HLT | ERR, 19, 1, "resume2_cyc");
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, RUNV | ERR, 19, 1, "resumed2");
    // reset in the middle of MEM_WAIT
    set_a(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, FRZ | ERR, 19, 1, "pre_rst_frz0");
    step(0, FRZ | ERR, 20, 1, "pre_rst_frz1");
    reset_n = 1'b0;
    step(0, ZERO, 0, 0, "in_reset0");
    step(0, ZERO, 0, 0, "in_reset1");
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    step(0, RUNV, 0, 0, "post_reset");
    // ack in the same cycle as the request: no stall
    set_a(0, 0, 0, 0, 0, 1, 1, 0, 0); step(0, RUNV, 0, 0, "same_cyc_ack");
    set_a(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, RUNV, 0, 0, "same_cyc_after");
    // LU_STALL=2, rs2 match on x7
    set_b(1, 7, 3, 7); step(1, LUV,  0, 0, "lu2_cyc0");
    set_b(0, 0, 0, 0); step(1, LUV,  1, 0, "lu2_cyc1");
    step(1, RUNV, 2, 0, "lu2_done");
    step(1, RUNV, 2, 0, "lu2_idle");
    @(negedge clk);
    #1;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    summary();
    $finish;
  end
endmodule
